fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//   Round-robin write-side arbiter sharing one fifo_memory between NUM_REQ producers.
//   Grants one producer a burst of up to MAX_BURST words, drives the FIFO write port.
//   Stalls on fifo_full, then rotates priority.
//   Sits directly in front of fifo_memory.write_enable/write_data; fifo_memory.full feeds back.
// PARAMETERS
//   NUM_REQ     4  number of producers (>=2)
//   DATA_WIDTH  8  word width, equals fifo_memory DATA_WIDTH
//   MAX_BURST   4  max words per grant (>=1)
// PORTS
//   clk                in   1                     single clock, rising edge
//   rstn               in   1                     reset: synchronous, active-HIGH
//   req                in   NUM_REQ               per-producer request; word valid while high
//   req_data           in   NUM_REQ*DATA_WIDTH    packed words, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt                out  NUM_REQ               one-hot; word of producer i accepted this cycle
//   fifo_full          in   1                     full flag from fifo_memory
//   fifo_write_enable  out  1                     write strobe to fifo_memory
//   fifo_write_data    out  DATA_WIDTH            write word to fifo_memory
//   owner              out  $clog2(NUM_REQ)       index of current burst owner
//   busy               out  1                     high while in BURST
// BEHAVIOUR
//   Reset (rstn=1 at a clock edge):
//     - state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
//     - All outputs are 0 in any cycle where rstn=1: gnt, fifo_write_enable, fifo_write_data, busy.
//   FSM IDLE (arbitration cycle, no transfer):
//     - If no req: stay IDLE.
//     - Else owner <= first i with req[i]=1, searching from rr_ptr upward with wrap mod NUM_REQ.
//     - Also burst_cnt <= 0, go BURST.
//   FSM BURST:
//     - Transfer when req[owner]=1 and fifo_full=0. Same cycle, combinational:
//       gnt[owner]=1, fifo_write_enable=1, fifo_write_data=req_data[owner], burst_cnt+1.
//     - req[owner]=1 and fifo_full=1: stall. No gnt, no write, burst_cnt held, stay BURST.
//       No timeout.
//     - req[owner]=0: burst ends with no transfer; go IDLE.
//     - A transfer with burst_cnt==MAX_BURST-1 ends the burst; go IDLE next cycle.
//     - Every burst exit sets rr_ptr <= (owner+1) mod NUM_REQ.
//   Handshake:
//     - Producer holds req and data stable until gnt.
//     - Producer may drop req only after a gnt, or before it is ever granted.
//     - gnt never asserted to a non-owner. fifo_write_enable == |gnt.
//   Latency and throughput:
//     - First gnt comes 1 cycle after req seen in IDLE.
//     - Peak rate is MAX_BURST words per MAX_BURST+1 cycles.
//   fifo_full is sampled combinationally. The arbiter never writes while full,
//   so fifo_memory cannot overflow.
//   owner changes only on an IDLE->BURST edge. rr_ptr wraps NUM_REQ-1 -> 0.
//   burst_cnt width is $clog2(MAX_BURST+1).
//   Reset mid-burst: the in-flight word is not written. Next cycle is IDLE with rr_ptr=0.
// TESTING
//   T1 reset:
//      Hold rstn=1 for 3 cycles with all req=1.
//      -> gnt=0, fifo_write_enable=0, busy=0, owner=0 throughout.
//   T2 single producer, MAX_BURST=4:
//      req[1]=1 for 6 words.
//      -> cycle0 IDLE; gnt[1] cycles 1-4; cycle5 IDLE with owner=1 again; gnt[1] cycles 6-7.
//      -> FIFO holds 6 words in order.
//   T3 all 4 req=1 continuously:
//      -> burst owners 0,1,2,3,0, each burst exactly 4 writes.
//      -> fifo_write_data matches each owner's data sequence.
//   T4 full stall:
//      owner=2; fifo_full=1 for 3 cycles after its 2nd word.
//      -> no gnt/write for those 3 cycles, busy=1.
//      -> then words 3-4 written, then IDLE.
//   T5 early drop:
//      owner=0 drops req after 2 words while req[3]=1.
//      -> BURST->IDLE, then owner=1 if req[1]=1, else owner=3.
//   T6 reset mid-burst:
//      rstn=1 during owner=3 burst after 1 word.
//      -> no write that cycle; next arbitration picks lowest requester from index 0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter: grants one producer at a time a burst of up to
// MAX_BURST words into a shared FIFO, stalling on fifo_full.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_write_enable,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t             state_p0, state_nxt;
  logic [IDX_W-1:0]   owner_p0;
  logic [IDX_W-1:0]   rr_ptr_p0;
  logic [CNT_W-1:0]   burst_cnt_p0;

  logic owner_req;
  logic in_burst;
  logic xfer;
  logic last_word;
  logic burst_exit;
  logic arb;

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && r[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign owner_req  = req[owner_p0];
  assign in_burst   = (state_p0 == BURST);
  assign xfer       = in_burst && owner_req && !fifo_full && !rstn;
  assign last_word  = (burst_cnt_p0 == CNT_W'(MAX_BURST - 1));
  assign burst_exit = in_burst && (!owner_req || (xfer && last_word));
  assign arb        = (state_p0 == IDLE) && (|req);

  always_ff @(posedge clk) begin
    if (rstn) state_p0 <= IDLE;
    else      state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (|req) state_nxt = BURST;
      BURST:   if (burst_exit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping: owner latches only on IDLE->BURST, pointer moves past it on exit.
  always_ff @(posedge clk) begin
    if (rstn) begin
      owner_p0     <= '0;
      rr_ptr_p0    <= '0;
      burst_cnt_p0 <= '0;
    end else begin
      if (arb) begin
        owner_p0     <= rr_pick(req, rr_ptr_p0);
        burst_cnt_p0 <= '0;
      end
      if (xfer)       burst_cnt_p0 <= burst_cnt_p0 + 1'b1;
      if (burst_exit) rr_ptr_p0    <= next_idx(owner_p0);
    end
  end

  always_comb begin
    gnt               = '0;
    fifo_write_enable = 1'b0;
    fifo_write_data   = '0;
    busy              = in_burst && !rstn;
    owner             = rstn ? '0 : owner_p0;
    if (xfer) begin
      gnt               = NUM_REQ'(1) << owner_p0;
      fifo_write_enable = 1'b1;
      fifo_write_data   = req_data[owner_p0*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-cycle expected grant, write data,
// busy and owner for reset, bursts, rotation, full stall, early drop and reset mid-burst.
module tb_fifo_write_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic                          clk = 1'b0;
  logic                          rstn;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_full;
  logic                          fifo_write_enable;
  logic [DATA_WIDTH-1:0]         fifo_write_data;
  logic [1:0]                    owner;
  logic                          busy;

  int n_chk  = 0;
  int n_bad  = 0;
  int n_step = 0;
  int seq[NUM_REQ];

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .req              (req),
    .req_data         (req_data),
    .gnt              (gnt),
    .fifo_full        (fifo_full),
    .fifo_write_enable(fifo_write_enable),
    .fifo_write_data  (fifo_write_data),
    .owner            (owner),
    .busy             (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance any
  // producer whose word the expectation says was accepted.
  task automatic step(input string tag, input logic rst, input logic [3:0] r, input logic f,
                      input logic [3:0] eg, input logic [7:0] ed, input logic eb,
                      input logic [1:0] eo);
    rstn      = rst;
    req       = r;
    fifo_full = f;
    for (int i = 0; i < NUM_REQ; i++)
      req_data[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(i*16 + seq[i]);
    @(negedge clk);
    chk($sformatf("%s/%0d gnt", tag, n_step),   32'(gnt),               32'(eg));
    chk($sformatf("%s/%0d we", tag, n_step),    32'(fifo_write_enable), 32'(|eg));
    chk($sformatf("%s/%0d data", tag, n_step),  32'(fifo_write_data),   32'(ed));
    chk($sformatf("%s/%0d busy", tag, n_step),  32'(busy),              32'(eb));
    chk($sformatf("%s/%0d owner", tag, n_step), 32'(owner),             32'(eo));
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (eg[i]) seq[i]++;
    n_step++;
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) seq[i] = 0;
    rstn      = 1'b1;
    req       = 4'hF;
    fifo_full = 1'b0;
    req_data  = '0;
    @(posedge clk);
    #1;

    // T1: reset held with every producer requesting
    for (int i = 0; i < 3; i++) step("t1", 1, 4'hF, 0, 4'h0, 8'h00, 0, 2'd0);

    // T2: producer 1 alone, six words -> bursts of 4 then 2
    step("t2", 0, 4'b0010, 0, 4'b0000, 8'h00, 0, 2'd0);
    step("t2", 0, 4'b0010, 0, 4'b0010, 8'h10, 1, 2'd1);
    step("t2", 0, 4'b0010, 0, 4'b0010, 8'h11, 1, 2'd1);
    step("t2", 0, 4'b0010, 0, 4'b0010, 8'h12, 1, 2'd1);
    step("t2", 0, 4'b0010, 0, 4'b0010, 8'h13, 1, 2'd1);
    step("t2", 0, 4'b0010, 0, 4'b0000, 8'h00, 0, 2'd1);
    step("t2", 0, 4'b0010, 0, 4'b0010, 8'h14, 1, 2'd1);
    step("t2", 0, 4'b0010, 0, 4'b0010, 8'h15, 1, 2'd1);
    step("t2", 0, 4'b0000, 0, 4'b0000, 8'h00, 1, 2'd1);
    step("t2", 0, 4'b0000, 0, 4'b0000, 8'h00, 0, 2'd1);

    // T3: everyone requesting from a fresh pointer -> owners 0,1,2,3,0
    step("t3rst", 1, 4'b0000, 0, 4'b0000, 8'h00, 0, 2'd0);
    for (int b = 0; b < 5; b++) begin
      int o;
      int prev;
      o    = b % NUM_REQ;
      prev = (b == 0) ? 0 : (b - 1) % NUM_REQ;
      step("t3arb", 0, 4'hF, 0, 4'b0000, 8'h00, 0, 2'(prev));
      for (int k = 0; k < MAX_BURST; k++)
        step("t3xfer", 0, 4'hF, 0, 4'(1 << o), 8'(o*16 + seq[o]), 1, 2'(o));
    end

    // T4: producer 2 stalled by fifo_full after its 2nd word
    step("t4", 0, 4'b0100, 0, 4'b0000, 8'h00, 0, 2'd0);
    step("t4", 0, 4'b0100, 0, 4'b0100, 8'h24, 1, 2'd2);
    step("t4", 0, 4'b0100, 0, 4'b0100, 8'h25, 1, 2'd2);
    step("t4full", 0, 4'b0100, 1, 4'b0000, 8'h00, 1, 2'd2);
    step("t4full", 0, 4'b0100, 1, 4'b0000, 8'h00, 1, 2'd2);
    step("t4full", 0, 4'b0100, 1, 4'b0000, 8'h00, 1, 2'd2);
    step("t4", 0, 4'b0100, 0, 4'b0100, 8'h26, 1, 2'd2);
    step("t4", 0, 4'b0100, 0, 4'b0100, 8'h27, 1, 2'd2);
    step("t4", 0, 4'b0000, 0, 4'b0000, 8'h00, 0, 2'd2);

    // T5: producer 0 drops early; next owner 1 (requesting), then 3
    step("t5rst", 1, 4'b0000, 0, 4'b0000, 8'h00, 0, 2'd0);
    step("t5", 0, 4'b1001, 0, 4'b0000, 8'h00, 0, 2'd0);
    step("t5", 0, 4'b1001, 0, 4'b0001, 8'h08, 1, 2'd0);
    step("t5", 0, 4'b1001, 0, 4'b0001, 8'h09, 1, 2'd0);
    step("t5", 0, 4'b1000, 0, 4'b0000, 8'h00, 1, 2'd0);
    step("t5", 0, 4'b1010, 0, 4'b0000, 8'h00, 0, 2'd0);
    step("t5", 0, 4'b1010, 0, 4'b0010, 8'h1A, 1, 2'd1);
    step("t5", 0, 4'b1000, 0, 4'b0000, 8'h00, 1, 2'd1);
    step("t5", 0, 4'b1000, 0, 4'b0000, 8'h00, 0, 2'd1);
    step("t5", 0, 4'b1000, 0, 4'b1000, 8'h34, 1, 2'd3);

    // T6: reset during owner 3's burst, then arbitration restarts from index 0
    step("t6rst", 1, 4'b1001, 0, 4'b0000, 8'h00, 0, 2'd0);
    step("t6", 0, 4'b1001, 0, 4'b0000, 8'h00, 0, 2'd0);
    step("t6", 0, 4'b1001, 0, 4'b0001, 8'h0A, 1, 2'd0);
    step("t6", 0, 4'b0000, 0, 4'b0000, 8'h00, 1, 2'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
